// File: rtl/loopback_checker.sv
// loopback_checker
//   Drives a single-bit registered path with an 8-bit LFSR stream and checks
//   the returned bit against a delayed copy of what was sent.
//
//   Parameters
//     LATENCY : pipeline depth of the path under test in clocks (1..8)
//     SEED    : LFSR load value, must be non-zero
//     CTR_W   : width of the RUN cycle counter
//     ERR_W   : width of the saturating mismatch counter
//
//   Ports
//     clk             in   sole clock, posedge
//     rst             in   synchronous, active-high reset
//     start           in   pulse, begins a run from IDLE
//     stop            in   pulse, ends the run (wins over start)
//     din             out  stimulus bit to the path under test
//     dout            in   returned bit from the path under test
//     running         out  high in FILL and RUN
//     err             out  sticky mismatch flag
//     err_cnt         out  saturating mismatch count
//     first_err_cycle out  cycle_cnt value at the first mismatch
//     cycle_cnt       out  compared cycles in the current/last run
module loopback_checker #(
  parameter int          LATENCY = 1,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter int          CTR_W   = 11,
  parameter int          ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic             din,
  input  logic             dout,
  output logic             running,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CTR_W-1:0] first_err_cycle,
  output logic [CTR_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [2:0] FILL_LAST = 3'(LATENCY - 1);

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic [7:0]         lfsr_r;
  logic               din_r;
  logic [LATENCY-1:0] hist_r;
  logic [LATENCY-1:0] hist_next_s;
  logic [2:0]         fill_cnt_r;
  logic               running_r;
  logic               err_r;
  logic [ERR_W-1:0]   err_cnt_r;
  logic [CTR_W-1:0]   first_err_r;
  logic [CTR_W-1:0]   cycle_cnt_r;
  logic               start_s;
  logic               mismatch_s;

  // History shift: bit LATENCY-1 holds the din value sent LATENCY cycles ago.
  generate
    if (LATENCY == 1) begin : g_hist_one
      assign hist_next_s = din_r;
    end else begin : g_hist_many
      assign hist_next_s = {hist_r[LATENCY-2:0], din_r};
    end
  endgenerate

  // A run only begins from IDLE, and a simultaneous stop cancels it.
  assign start_s    = (state_r == ST_IDLE) && start && !stop;
  assign mismatch_s = (state_r == ST_RUN) && (dout != hist_r[LATENCY-1]);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (stop) begin
          state_next_s = ST_IDLE;
        end else if (fill_cnt_r == FILL_LAST) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Stimulus generation, history and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r      <= SEED;
      din_r       <= 1'b0;
      hist_r      <= {LATENCY{1'b0}};
      fill_cnt_r  <= 3'd0;
      running_r   <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= {ERR_W{1'b0}};
      first_err_r <= {CTR_W{1'b0}};
      cycle_cnt_r <= {CTR_W{1'b0}};
    end else begin
      running_r <= (state_next_s != ST_IDLE);
      if (start_s) begin
        // SEED bit7 goes out now, so the register already holds the next step.
        lfsr_r      <= lfsr_next(SEED);
        din_r       <= SEED[7];
        hist_r      <= {LATENCY{1'b0}};
        fill_cnt_r  <= 3'd0;
        err_r       <= 1'b0;
        err_cnt_r   <= {ERR_W{1'b0}};
        first_err_r <= {CTR_W{1'b0}};
        cycle_cnt_r <= {CTR_W{1'b0}};
      end else if (state_r != ST_IDLE) begin
        hist_r <= hist_next_s;
        if (stop) begin
          din_r <= 1'b0;
        end else begin
          din_r  <= lfsr_r[7];
          lfsr_r <= lfsr_next(lfsr_r);
        end
        if (state_r == ST_FILL) begin
          fill_cnt_r <= fill_cnt_r + 3'd1;
        end
        // The compare in a stop cycle still counts.
        if (state_r == ST_RUN) begin
          cycle_cnt_r <= cycle_cnt_r + {{(CTR_W-1){1'b0}}, 1'b1};
          if (mismatch_s) begin
            err_r <= 1'b1;
            if (err_cnt_r != {ERR_W{1'b1}}) begin
              err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            if (!err_r) begin
              first_err_r <= cycle_cnt_r;
            end
          end
        end
      end else begin
        din_r <= 1'b0;
      end
    end
  end

  assign din             = din_r;
  assign running         = running_r;
  assign err             = err_r;
  assign err_cnt         = err_cnt_r;
  assign first_err_cycle = first_err_r;
  assign cycle_cnt       = cycle_cnt_r;

endmodule

// File: doc/loopback_checker.md
# loopback_checker

Stimulus-and-check companion for the single-bit registered path (`din` → `dout`, one flop per stage). It drives `din` with an 8-bit LFSR bit stream. It compares the returned `dout` against its own delayed copy of `din`, and reports a sticky error flag, a saturating mismatch count and the RUN cycle of the first mismatch. It sits in the top-level testbench alongside the path under test and shares its clock.

## Interface
- `LATENCY`, 1: pipeline depth of the path under test in clocks (1..8)
- `SEED`, 8'hA5: LFSR load value; must be non-zero
- `CTR_W`, 11: width of the RUN cycle counter
- `ERR_W`, 8: width of the mismatch counter
- `clk`  in  1  sole clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse; begin a run from IDLE
- `stop`  in  1  single-cycle pulse; end the run, stats held
- `din`  out  1  stimulus bit to the path under test
- `dout`  in  1  returned bit from the path under test
- `running`  out  1  high in FILL and RUN
- `err`  out  1  sticky; set on first mismatch
- `err_cnt`  out  ERR_W  mismatch count, saturating
- `first_err_cycle`  out  CTR_W  `cycle_cnt` value at first mismatch
- `cycle_cnt`  out  CTR_W  compared cycles in current/last run

## Operation
- States: IDLE, FILL, RUN.
- **IDLE**
  - `din` = 0 and the LFSR holds.
  - On `start`: load LFSR ← `SEED`; clear `err`, `err_cnt`, `first_err_cycle` and `cycle_cnt`; go to FILL.
- **FILL**
  - Lasts exactly `LATENCY` cycles; no compares.
  - The LFSR advances every cycle, then the block goes to RUN.
- **RUN**
  - The LFSR advances every cycle.
  - Each cycle, compare sampled `dout` with the `din` value driven `LATENCY` cycles earlier (history shift register, depth `LATENCY`).
  - `cycle_cnt` increments after each compare.
- **LFSR**
  - Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shift left.
  - New bit0 = b7^b5^b4^b3.
  - `din` = LFSR bit7, registered.
  - Period 255.
- **On mismatch**
  - `err` ← 1.
  - `err_cnt` ← `err_cnt`+1, saturating at 2^ERR_W−1.
  - If `err` was 0: `first_err_cycle` ← current `cycle_cnt`.
- `cycle_cnt` wraps modulo 2^CTR_W. Wrap does not affect errors; `first_err_cycle` is taken modulo as well.
- `stop` in FILL or RUN → IDLE. `din` returns to 0 the next cycle; all stats hold until the next `start`.
- `start` in FILL or RUN is ignored.
- `start` and `stop` asserted in the same cycle: `stop` wins. From IDLE this means no run starts.
- Mismatch and `stop` in the same RUN cycle: that compare is still counted.

## Timing
- **Reset values:** `din`=0, `running`=0, `err`=0, `err_cnt`=0, `first_err_cycle`=0, `cycle_cnt`=0; state IDLE; LFSR=`SEED`; history cleared.
- `rst` has priority over `start` and `stop`. Reset mid-run aborts immediately, with no final compare.
- **Start latency:**
  - `start` sampled at edge E → `running`=1 and the first LFSR bit on `din` after E.
  - First compare at edge E+`LATENCY`+1.
- All outputs are registered. A mismatch sampled at edge N is visible on `err`/`err_cnt` after N.
- `stop` sampled at edge N → `running`=0 after N.

## Test plan
- **Ideal 1-flop path, `LATENCY`=1:** `start`, run 1000 cycles, `stop` → `err`=0, `err_cnt`=0, `cycle_cnt`=1000. The first 8 `din` bits are 1,0,1,0,0,1,0,1 (SEED bits 7..0).
- **Injected fault, `LATENCY`=1:** invert `dout` only on the compare where `cycle_cnt`=40 → `err`=1, `err_cnt`=1, `first_err_cycle`=40. No further increments.
- **Saturation, `ERR_W`=4:** invert `dout` continuously for 40 RUN cycles → `err_cnt`=15 and held; `first_err_cycle`=0.
- **Wrap, `CTR_W`=11:** ideal path for 2050 RUN cycles → `cycle_cnt`=2. Inject a fault at cycle 2049 → `first_err_cycle`=1.
- **Control priority:**
  - `start` and `stop` together in IDLE → stays IDLE, `running`=0.
  - `start` during RUN → no stat clear.
- **Reset mid-run:** `rst` at RUN cycle 100 after an injected error → all outputs 0 the next cycle. A later `start` reproduces the identical `din` sequence from `SEED`.
